// File: rtl/key_debounce.sv
// key_debounce: per-key two-flop synchroniser, bounce filter and one-cycle press/release pulses.
// Define KEY_DEBOUNCE_ACTIVE_LOW_EN for buttons that pull the pin low when pressed.
module key_debounce #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned CNT_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release
);

    localparam int unsigned     CntW    = $clog2(CNT_MAX);
    localparam logic [CntW-1:0] CntLast = CntW'(CNT_MAX - 1);

    logic [WIDTH-1:0]           raw_pressed;
    logic [WIDTH-1:0]           s1_q;
    logic [WIDTH-1:0]           s2_q;
    logic [WIDTH-1:0]           key_q;
    logic [WIDTH-1:0]           key_d;
    logic [WIDTH-1:0]           press_q;
    logic [WIDTH-1:0]           press_d;
    logic [WIDTH-1:0]           release_q;
    logic [WIDTH-1:0]           release_d;
    logic [WIDTH-1:0]           accept;
    logic [WIDTH-1:0][CntW-1:0] cnt_q;
    logic [WIDTH-1:0][CntW-1:0] cnt_d;

`ifdef KEY_DEBOUNCE_ACTIVE_LOW_EN
    assign raw_pressed = ~key_raw;
`else
    assign raw_pressed = key_raw;
`endif

    // A new level is accepted on the CNT_MAX-th consecutive edge it differs from key_q.
    always_comb begin
        accept = '0;
        cnt_d  = cnt_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (s2_q[i] == key_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                accept[i] = 1'b1;
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
        key_d     = (key_q & ~accept) | (s2_q & accept);
        press_d   = accept & s2_q;
        release_d = accept & ~s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            key_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= raw_pressed;
            s2_q      <= s1_q;
            key_q     <= key_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
        end
    end

    assign key         = key_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce (WIDTH=4, CNT_MAX=4) against a sliding-window reference.
module tb_key_debounce;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned CNT_MAX = 4;
`ifdef KEY_DEBOUNCE_ACTIVE_LOW_EN
    localparam logic [WIDTH-1:0] POL = 4'hF;
`else
    localparam logic [WIDTH-1:0] POL = 4'h0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] key_raw = 4'hF;
    logic [WIDTH-1:0] key;
    logic [WIDTH-1:0] key_press;
    logic [WIDTH-1:0] key_release;

    int checks = 0;
    int errors = 0;

    key_debounce #(
        .WIDTH  (WIDTH),
        .CNT_MAX(CNT_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_raw    (key_raw),
        .key        (key),
        .key_press  (key_press),
        .key_release(key_release)
    );

    always #5 clk = ~clk;

    // Reference: a key level flips once the last CNT_MAX synchronised samples all disagree with it.
    logic [WIDTH-1:0] m_s1 = '0, m_s2 = '0, m_key = '0, m_press = '0, m_rel = '0;
    logic [WIDTH-1:0] win[$];

    always @(posedge clk) begin
        logic [WIDTH-1:0] samp;
        logic             all_diff;
        m_press = '0;
        m_rel   = '0;
        if (rst) begin
            m_s1  = '0;
            m_s2  = '0;
            m_key = '0;
            win.delete();
        end else begin
            samp = m_s2;
            m_s2 = m_s1;
            m_s1 = key_raw ^ POL;
            win.push_back(samp);
            if (win.size() > CNT_MAX) void'(win.pop_front());
            if (win.size() == CNT_MAX) begin
                for (int i = 0; i < WIDTH; i++) begin
                    all_diff = 1'b1;
                    foreach (win[k]) if (win[k][i] == m_key[i]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_key[i] = ~m_key[i];
                        if (m_key[i]) m_press[i] = 1'b1;
                        else          m_rel[i]   = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_keys(input logic [WIDTH-1:0] pressed);
        key_raw = pressed ^ POL;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        key_raw = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({key, key_press, key_release} !== 12'h000) begin
                errors++;
                $display("FAIL reset cyc %0d: got key=%b press=%b rel=%b, want all 0",
                         c, key, key_press, key_release);
            end
        end
        set_keys(4'b0000);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if ({key, key_press, key_release} !== 12'h000) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: got key=%b press=%b rel=%b, want all 0",
                         c, key, key_press, key_release);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [WIDTH-1:0] ek, ep;
        set_keys(4'b0001);
        for (int e = 1; e <= 10; e++) begin
            tick();
            ek = (e >= 6) ? 4'b0001 : 4'b0000;
            ep = (e == 6) ? 4'b0001 : 4'b0000;
            checks++;
            if ({key, key_press, key_release} !== {ek, ep, 4'b0000} ||
                {key, key_press, key_release} !== {m_key, m_press, m_rel}) begin
                errors++;
                $display("FAIL clean_press E%0d: got key=%b press=%b rel=%b, want key=%b press=%b rel=0000",
                         e, key, key_press, key_release, ek, ep);
            end
        end
    endtask

    task automatic test_bounce();
        // bit1 high 3, low 1, high 2, then low; bit0 stays held
        logic [5:0] pat = 6'b110111;
        for (int c = 0; c < 14; c++) begin
            set_keys({2'b00, (c < 6) ? pat[c] : 1'b0, 1'b1});
            tick();
            checks++;
            if (key[1] !== 1'b0 || key_press[1] !== 1'b0 ||
                {key, key_press, key_release} !== {m_key, m_press, m_rel}) begin
                errors++;
                $display("FAIL bounce cyc %0d: got key=%b press=%b rel=%b, want key=%b press=%b rel=%b",
                         c, key, key_press, key_release, m_key, m_press, m_rel);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [WIDTH-1:0] ek, ep, er;
        set_keys(4'b0101);
        for (int c = 0; c < 8; c++) tick();
        checks++;
        if (key !== 4'b0101) begin
            errors++;
            $display("FAIL simul_setup: got key=%b, want 0101", key);
        end
        set_keys(4'b1010);
        for (int e = 1; e <= 8; e++) begin
            tick();
            ek = (e >= 6) ? 4'b1010 : 4'b0101;
            ep = (e == 6) ? 4'b1010 : 4'b0000;
            er = (e == 6) ? 4'b0101 : 4'b0000;
            checks++;
            if ({key, key_press, key_release} !== {ek, ep, er} ||
                {key, key_press, key_release} !== {m_key, m_press, m_rel}) begin
                errors++;
                $display("FAIL simul E%0d: got key=%b press=%b rel=%b, want key=%b press=%b rel=%b",
                         e, key, key_press, key_release, ek, ep, er);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] ek, ep;
        // reset while keys are held down must not produce release pulses
        rst = 1'b1;
        tick();
        checks++;
        if ({key, key_press, key_release} !== 12'h000) begin
            errors++;
            $display("FAIL reset_held: got key=%b press=%b rel=%b, want all 0",
                     key, key_press, key_release);
        end
        set_keys(4'b0000);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        set_keys(4'b1000);
        for (int c = 0; c < 4; c++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({key, key_press, key_release} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_edge: got key=%b press=%b rel=%b, want all 0",
                     key, key_press, key_release);
        end
        rst = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            ek = (e >= 6) ? 4'b1000 : 4'b0000;
            ep = (e == 6) ? 4'b1000 : 4'b0000;
            checks++;
            if ({key, key_press, key_release} !== {ek, ep, 4'b0000} ||
                {key, key_press, key_release} !== {m_key, m_press, m_rel}) begin
                errors++;
                $display("FAIL reset_mid E%0d: got key=%b press=%b rel=%b, want key=%b press=%b rel=0000",
                         e, key, key_press, key_release, ek, ep);
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] cur = 4'b1000;
        int               hold = 0;
        for (int c = 0; c < 600; c++) begin
            if (hold == 0) begin
                cur  = cur ^ WIDTH'($urandom_range(0, 15));
                hold = $urandom_range(1, 8);
            end
            hold--;
            set_keys(cur);
            rst = ($urandom_range(0, 99) == 0);
            tick();
            checks++;
            if ({key, key_press, key_release} !== {m_key, m_press, m_rel} ||
                (key_press & key_release) !== 4'b0000) begin
                errors++;
                $display("FAIL random cyc %0d: got key=%b press=%b rel=%b, want key=%b press=%b rel=%b",
                         c, key, key_press, key_release, m_key, m_press, m_rel);
            end
        end
        rst = 1'b0;
    endtask

`ifdef KEY_DEBOUNCE_ACTIVE_LOW_EN
    task automatic test_active_low();
        logic [WIDTH-1:0] ek, ep;
        rst     = 1'b1;
        key_raw = 4'b1111;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if ({key, key_press, key_release} !== 12'h000) begin
                errors++;
                $display("FAIL active_low_idle cyc %0d: got key=%b press=%b rel=%b, want all 0",
                         c, key, key_press, key_release);
            end
        end
        key_raw = 4'b1110;
        for (int e = 1; e <= 8; e++) begin
            tick();
            ek = (e >= 6) ? 4'b0001 : 4'b0000;
            ep = (e == 6) ? 4'b0001 : 4'b0000;
            checks++;
            if ({key, key_press, key_release} !== {ek, ep, 4'b0000}) begin
                errors++;
                $display("FAIL active_low E%0d: got key=%b press=%b rel=%b, want key=%b press=%b rel=0000",
                         e, key, key_press, key_release, ek, ep);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_random();
`ifdef KEY_DEBOUNCE_ACTIVE_LOW_EN
        test_active_low();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
# key_debounce

Per-key input conditioning stage in front of the lab key-decode logic. It synchronises the raw push-button inputs into the system clock domain and removes contact bounce. It presents clean, stable key levels on `key`, which feed the downstream combinational LED logic directly. It also produces one-cycle press and release pulses per key for sequential consumers.

## Interface
- `WIDTH`, 4: number of independent keys.
- `CNT_MAX`, 16: consecutive cycles a new synchronised level must persist before it is accepted. Legal range 2..65535. Benches use 4; board builds use the value matching roughly 10 ms.
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `key_raw` input `WIDTH`: asynchronous raw button levels.
- `key` output `WIDTH`: debounced level, 1 = pressed; connects to the key-decode block.
- `key_press` output `WIDTH`: one-cycle pulse when the corresponding `key` bit goes 0→1.
- `key_release` output `WIDTH`: one-cycle pulse when the corresponding `key` bit goes 1→0.

## Operation
- Per bit i, independent and identical:
  - two-flop synchroniser `s1[i]` → `s2[i]`;
  - stable register `key[i]`;
  - counter `cnt_i`, width `$clog2(CNT_MAX)`.
- Each rising edge, with `rst`=0:
  - `s2[i]` == `key[i]`: `cnt_i` <= 0; `key[i]` holds.
  - `s2[i]` != `key[i]` and `cnt_i` < `CNT_MAX-1`: `cnt_i` <= `cnt_i`+1.
  - `s2[i]` != `key[i]` and `cnt_i` == `CNT_MAX-1`: `key[i]` <= `s2[i]`; `cnt_i` <= 0.
- Any return of `s2[i]` to the stable value before acceptance clears `cnt_i`. A bounce shorter than `CNT_MAX` cycles therefore never reaches `key`, and the next change restarts counting from 0.
- `key_press[i]` is registered: 1 for exactly the cycle in which `key[i]` first reads 1 after being 0; 0 otherwise.
- `key_release[i]` is symmetric for the 1→0 transition.
- `key_press[i]` and `key_release[i]` are never both 1.
- Simultaneous changes on several bits are handled independently, with no priority. Any subset of pulses may assert in the same cycle.
- No arithmetic overflow is possible: `cnt_i` never exceeds `CNT_MAX-1`.

## Timing
- Reset: `s1`, `s2`, `key`, all counters, `key_press` and `key_release` <= 0 on the first rising edge with `rst`=1. They hold 0 while `rst`=1.
- Latency:
  - `key_raw[i]` changes and stays stable; the first edge sampling the new value is E1.
  - `key[i]` and the pulse update on edge E(`CNT_MAX`+2). For `CNT_MAX`=4 that is edge E6.
- Pulse width: exactly 1 clock. A key held indefinitely gives one `key_press` only.
- Reset mid-count: the counter and level are cleared. If the key is still held after `rst` falls, `key` rises `CNT_MAX`+2 edges after the first non-reset edge, with a `key_press` pulse.
- Reset never generates a `key_release` pulse, even if `key` was 1.
- Reset deasserted with `key_raw` = 0: outputs stay 0, with no spurious pulse.

## Configuration
- `KEY_DEBOUNCE_ACTIVE_LOW_EN`:
  - Defined: `key_raw` is inverted before `s1`, so a board button pulling the pin low reads as `key`=1. Reset values are unchanged (all 0). With `key_raw` idle high after reset, no `key_press` pulse occurs.
  - Undefined: `key_raw` is used as-is, so high means pressed.

## Test plan
- Reset: `rst`=1 for 3 cycles with `key_raw`=4'b1111 → `key`, `key_press` and `key_release` = 0 throughout.
- Clean press, `CNT_MAX`=4: after reset, set `key_raw`=4'b0001 and hold.
  - Required: `key`=4'b0001 first seen at edge E6.
  - Required: `key_press`=4'b0001 for that single cycle, then 0.
  - Required: no further pulses while held.
- Bounce rejection: `key_raw[1]` toggles high 3 cycles, low 1 cycle, high 2 cycles, then low.
  - Required: `key[1]` stays 0.
  - Required: `key_press[1]` never asserts.
- Release and simultaneity: with `key`=4'b0101 stable, set `key_raw`=4'b1010 in one cycle.
  - Required: after 6 edges, `key`=4'b1010.
  - Required: `key_press`=4'b1010 and `key_release`=4'b0101 in the same single cycle.
- Reset mid-operation: hold `key_raw`=4'b1000, assert `rst` for 1 cycle at count 2, then release.
  - Required: `key[3]` rises 6 edges after `rst` falls, with one `key_press[3]` pulse.
  - Required: no `key_release` pulse.
- Active-low build (`KEY_DEBOUNCE_ACTIVE_LOW_EN` defined): idle `key_raw`=4'b1111 gives `key`=0. Driving `key_raw`=4'b1110 gives `key`=4'b0001 after 6 edges.
